// File: rtl/spi_xfer_arbiter.sv
// spi_xfer_arbiter: round-robin sharing of one spi_core register bus between requesters
module spi_xfer_arbiter #(
  parameter int          N_REQ      = 2,
  parameter int          SS_NB      = 8,
  parameter logic [7:0]  OFS_RX_TX0 = 8'h00,
  parameter logic [7:0]  OFS_CTRL   = 8'h10,
  parameter logic [7:0]  OFS_DIV    = 8'h14,
  parameter logic [7:0]  OFS_SS     = 8'h18,
  parameter logic [15:0] POLL_MAX   = 16'hFFFF
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic [15:0]            divider_i,
  input  logic [N_REQ-1:0]       req_i,
  input  logic [N_REQ*SS_NB-1:0] ss_i,
  input  logic [N_REQ*7-1:0]     len_i,
  input  logic [N_REQ*3-1:0]     mode_i,
  input  logic [N_REQ*32-1:0]    tx_i,
  output logic [N_REQ-1:0]       gnt_o,
  output logic [N_REQ-1:0]       done_o,
  output logic [31:0]            rx_o,
  output logic                   err_o,
  output logic                   busy_o,
  output logic [7:0]             addr_o,
  output logic [31:0]            wdata_o,
  output logic [3:0]             be_o,
  output logic                   we_o,
  output logic                   re_o,
  input  logic [31:0]            rdata_i
);
  localparam int IW = (N_REQ > 2) ? 2 : 1;
  typedef enum logic [3:0] {IDLE, ARB, WR_DIV, WR_SS, WR_TX, WR_CTRL, POLL_RD, POLL_CHK, RD_RX, RD_CAP, DONE} state_t;
  state_t state;
  logic [IW-1:0] ptr, win, idx;
  logic [SS_NB-1:0] ss;
  logic [6:0] len;
  logic [2:0] mode;
  logic [31:0] tx;
  logic [15:0] polls;
  assign busy_o = state != IDLE;
  // first requester at or after the pointer, wrapping around
  always_comb begin
    win = '0;
    for (int i = N_REQ - 1; i >= 0; i--)
      if (req_i[(int'(ptr) + i) % N_REQ]) win = IW'((int'(ptr) + i) % N_REQ);
  end
  // sequencer: outputs are registered alongside the state they belong to
  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) begin
      state <= IDLE; ptr <= '0; idx <= '0; ss <= '0; len <= '0; mode <= '0; tx <= '0; polls <= '0;
      gnt_o <= '0; done_o <= '0; rx_o <= '0; err_o <= 1'b0;
      addr_o <= '0; wdata_o <= '0; be_o <= '0; we_o <= 1'b0; re_o <= 1'b0;
    end else begin
      gnt_o <= '0; done_o <= '0; err_o <= 1'b0;
      addr_o <= '0; wdata_o <= '0; be_o <= '0; we_o <= 1'b0; re_o <= 1'b0;
      case (state)
        IDLE: state <= (|req_i) ? ARB : IDLE;
        ARB: if (|req_i) begin
          state <= WR_DIV;
          idx <= win;
          ptr <= (win == IW'(N_REQ - 1)) ? '0 : win + 1'b1;
          ss <= ss_i[win*SS_NB +: SS_NB];
          len <= len_i[win*7 +: 7];
          mode <= mode_i[win*3 +: 3];
          tx <= tx_i[win*32 +: 32];
          polls <= '0;
          gnt_o <= N_REQ'(1) << win;
          we_o <= 1'b1; addr_o <= OFS_DIV; wdata_o <= {16'b0, divider_i}; be_o <= 4'b0011;
        end else state <= IDLE;
        WR_DIV: begin
          state <= WR_SS;
          we_o <= 1'b1; addr_o <= OFS_SS; wdata_o <= 32'(ss); be_o <= 4'b0001;
        end
        WR_SS: begin
          state <= WR_TX;
          we_o <= 1'b1; addr_o <= OFS_RX_TX0; wdata_o <= tx; be_o <= 4'b1111;
        end
        WR_TX: begin
          state <= WR_CTRL;
          we_o <= 1'b1; addr_o <= OFS_CTRL; be_o <= 4'b0011;
          wdata_o <= {18'b0, 1'b1, 1'b0, mode, 1'b1, 1'b0, len};
        end
        WR_CTRL: begin
          state <= POLL_RD;
          re_o <= 1'b1; addr_o <= OFS_CTRL;
        end
        POLL_RD: begin
          state <= POLL_CHK;
          polls <= (polls == 16'hFFFF) ? polls : polls + 1'b1;
          re_o <= 1'b1; addr_o <= OFS_CTRL;
        end
        POLL_CHK:
          if (!rdata_i[8]) begin
            state <= RD_RX; re_o <= 1'b1; addr_o <= OFS_RX_TX0;
          end else if (polls < POLL_MAX) begin
            state <= POLL_RD; re_o <= 1'b1; addr_o <= OFS_CTRL;
          end else begin
            state <= DONE; done_o <= N_REQ'(1) << idx; err_o <= 1'b1;
          end
        RD_RX: state <= RD_CAP;
        RD_CAP: begin
          state <= DONE; rx_o <= rdata_i; done_o <= N_REQ'(1) << idx;
        end
        default: state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_spi_xfer_arbiter.sv
// tb_spi_xfer_arbiter: directed and random transfers against a loopback spi_core bus model
module tb_spi_xfer_arbiter;
  localparam int N = 3;
  localparam logic [15:0] PMAX = 16'd4;
  logic clk = 0, rst = 0;
  logic [15:0] d_div;
  logic [N-1:0] req = '0;
  logic [7:0] d_ss [N];
  logic [6:0] d_len [N];
  logic [2:0] d_mode [N];
  logic [31:0] d_tx [N];
  logic [N*8-1:0] ss_v;
  logic [N*7-1:0] len_v;
  logic [N*3-1:0] mode_v;
  logic [N*32-1:0] tx_v;
  logic [N-1:0] gnt, done;
  logic [31:0] rx, wdata, rdata = 0;
  logic err, busy, we, re;
  logic [7:0] addr;
  logic [3:0] be;
  int vectors = 0, miscompares = 0, mptr = 0, nrd = 0, blen = 0, bcnt = 0;
  bit stall = 0, in_poll = 0;
  logic [31:0] last_rx = 0, m_tx = 0, m_rx = 0, m_ctrl = 0;
  logic [43:0] wlog [$];
  always #5 clk = ~clk;
  for (genvar g = 0; g < N; g++) begin : pk
    assign ss_v[g*8 +: 8] = d_ss[g];
    assign len_v[g*7 +: 7] = d_len[g];
    assign mode_v[g*3 +: 3] = d_mode[g];
    assign tx_v[g*32 +: 32] = d_tx[g];
  end
  spi_xfer_arbiter #(.N_REQ(N), .POLL_MAX(PMAX)) dut (
    .clk_i(clk), .rst_i(rst), .divider_i(d_div), .req_i(req), .ss_i(ss_v), .len_i(len_v),
    .mode_i(mode_v), .tx_i(tx_v), .gnt_o(gnt), .done_o(done), .rx_o(rx), .err_o(err),
    .busy_o(busy), .addr_o(addr), .wdata_o(wdata), .be_o(be), .we_o(we), .re_o(re), .rdata_i(rdata)
  );
  // spi_core stand-in: GO stays set for blen cycles (forever when stalled), RX loops back TX
  always @(posedge clk) begin
    if (we && addr == 8'h00) m_tx <= wdata;
    if (we && addr == 8'h10) begin
      m_ctrl <= wdata;
      if (wdata[8]) begin bcnt <= stall ? -1 : blen; m_rx <= m_tx; end
    end else if (bcnt > 0) bcnt <= bcnt - 1;
    rdata <= !re ? 32'h0 : addr == 8'h10 ? {m_ctrl[31:9], bcnt != 0, m_ctrl[7:0]} : addr == 8'h00 ? m_rx : 32'h0;
  end
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic step();
    @(negedge clk);
    chk("rw_excl", 64'(we & re), 0);
    chk("idle_bus", (we | re) ? 64'h0 : 64'({addr, be, wdata}), 0);
    chk("wr_in_poll", 64'(in_poll & we), 0);
    if (we) begin
      wlog.push_back({addr, be, wdata});
      if (addr == 8'h10) in_poll = 1;
    end
    if (re && addr == 8'h10) nrd++;
    if (done != 0) in_poll = 0;
  endtask
  task automatic rnd(input int k);
    d_div = 16'($urandom);
    d_ss[k] = 8'($urandom);
    d_len[k] = 7'($urandom_range(1, 32));
    d_mode[k] = 3'($urandom);
    d_tx[k] = $urandom;
  endtask
  function automatic int pick(input logic [N-1:0] p);
    for (int i = 0; i < N; i++) if (p[(mptr + i) % N]) return (mptr + i) % N;
    return 0;
  endfunction
  task automatic run(input logic [N-1:0] mask, input bit hold, input int rounds);
    logic [N-1:0] pend;
    logic [31:0] e_rx;
    logic [43:0] e_wr [4];
    int k, n, t, p;
    pend = mask; n = 0; req = mask;
    while (pend != 0 && n < rounds) begin
      k = pick(pend); mptr = (k + 1) % N; n++;
      e_wr[0] = {8'h14, 4'h3, 16'h0, d_div};
      e_wr[1] = {8'h18, 4'h1, 24'h0, d_ss[k]};
      e_wr[2] = {8'h00, 4'hF, d_tx[k]};
      e_wr[3] = {8'h10, 4'h3, 32'h2100 | 32'(d_len[k]) | (32'(d_mode[k]) << 9)};
      e_rx = stall ? last_rx : d_tx[k];
      p = stall ? int'(PMAX) : (blen == 0 ? 1 : (blen + 1) / 2 + 1);
      wlog.delete(); nrd = 0;
      step(); t = 1;
      while (gnt == 0 && t < 20) begin step(); t++; end
      chk("gnt", 64'(gnt), 64'(N'(1) << k));
      if (!hold) begin pend[k] = 1'b0; req[k] = 1'b0; end
      rnd(k);
      t = 0;
      while (done == 0 && t < 60) begin step(); t++; end
      chk("done", 64'(done), 64'(N'(1) << k));
      chk("latency", 64'(t), 64'(stall ? 4 + 2 * p : 6 + 2 * p));
      chk("ctrl_reads", 64'(nrd), 64'(2 * p));
      chk("rx", 64'(rx), 64'(e_rx));
      chk("err", 64'(err), 64'(stall));
      chk("n_writes", 64'(wlog.size()), 4);
      for (int i = 0; i < 4 && i < wlog.size(); i++) chk($sformatf("write%0d", i), 64'(wlog[i]), 64'(e_wr[i]));
      last_rx = e_rx;
      step();
      chk("idle_after_done", 64'(busy), 0);
    end
    req = '0;
  endtask
  initial begin
    int t;
    for (int i = 0; i < N; i++) rnd(i);
    #1 rst = 1;
    step(); step();
    chk("rst_ctl", 64'({gnt, done, err, busy, addr, be, we, re}), 0);
    chk("rst_rx", 64'(rx), 0);
    rst = 0;
    step();
    d_div = 16'd4; d_ss[0] = 8'h01; d_len[0] = 7'd8; d_mode[0] = 3'b000; d_tx[0] = 32'hA5;
    run(3'b001, 0, 1);
    d_len[2] = 7'd32; d_mode[2] = 3'b100; d_tx[2] = 32'hDEADBEEF; blen = 3;
    run(3'b100, 0, 1);
    blen = 1;
    run(3'b011, 1, 4);
    stall = 1;
    run(3'b001, 0, 1);
    stall = 0; blen = 5;
    req = 3'b011;
    step(); t = 1;
    while (gnt == 0 && t < 20) begin step(); t++; end
    chk("gnt_pre_rst", 64'(gnt), 64'(3'b010));
    t = 0;
    while (!(re && addr == 8'h10) && t < 20) begin step(); t++; end
    chk("in_poll_rd", 64'(re), 1);
    rst = 1;
    #1;
    chk("async_rst_ctl", 64'({gnt, done, err, busy, addr, be, we, re}), 0);
    chk("async_rst_bus", 64'({rx, wdata}), 0);
    for (int i = 0; i < 3; i++) begin step(); chk("no_done_in_rst", 64'(done), 0); end
    rst = 0; in_poll = 0; mptr = 0; last_rx = 0;
    run(3'b011, 0, N);
    for (int i = 0; i < 25; i++) begin
      blen = $urandom_range(0, 5);
      run(N'($urandom_range(1, 7)), 0, N);
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
